fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage plus IF/ID pipeline register: owns the PC, fetches one instruction at a time from instruction memory over a req/rvalid handshake, and presents {pc, instr, valid} to decode.
- Consumes the branch unit's redirect pair (PcSel, BrPC) from EX.
- Holds under hazard-unit stall.
- Flushes and drops in-flight fetches on redirect.

Parameters:
- PC_W, 9, PC width in bits (byte address).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold the IF/ID outputs and do not advance the PC.
- PcSel  input  1  branch/jump taken in EX; redirect the PC to BrPC.
- BrPC  input  32  redirect target; bits [PC_W-1:2] used, [1:0] forced to 0.
- imem_req  output  1  fetch request, single-cycle pulse.
- imem_addr  output  PC_W  fetch address, equal to the PC register.
- imem_rvalid  input  1  response valid; latency 1..N cycles after req.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- if_pc  output  PC_W  PC of the instruction in IF/ID.
- if_instr  output  32  instruction in IF/ID.
- if_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (synchronous, priority over everything):
  - pc = RESET_PC; state = REQ.
  - if_valid = 0, if_instr = 32'h00000013 (NOP), if_pc = 0.
  - hold buffer cleared.
  - imem_req = 0 while reset is high.
- Outstanding fetches: at most one.
- imem_req = (state==REQ) && !PcSel && !reset, combinational. imem_addr = pc.
- States:
  - REQ: request issued this cycle → WAIT.
  - WAIT: on imem_rvalid:
    - stall=0: load IF/ID ← {pc, imem_rdata, 1}; pc ← pc+4; → REQ.
    - stall=1: capture rdata into the hold buffer; → HOLD.
  - HOLD: when stall=0, load IF/ID from the hold buffer, pc ← pc+4, → REQ.
  - DRAIN: wait for imem_rvalid, discard its data; → REQ.
- IF/ID when no load occurs:
  - stall=1: IF/ID holds all values.
  - stall=0: if_valid ← 0; if_pc/if_instr may hold.
- Redirect (PcSel=1) has priority over stall and rvalid:
  - pc ← {BrPC[PC_W-1:2],2'b00}; if_valid ← 0 (flush, even if stall=1).
  - Next state:
    - REQ: no request issued this cycle; stay REQ.
    - WAIT with rvalid the same cycle: response discarded; → REQ.
    - WAIT without rvalid: → DRAIN.
    - HOLD: buffer discarded; → REQ.
    - DRAIN: stays DRAIN; target updated.
  - First fetch of the target issues the cycle after leaving to REQ.
- Arithmetic: pc+4 is modulo 2^PC_W; wrap from max word to 0 is legal.
- Throughput: 1 instruction per (2 + memory latency − 1) cycles with one outstanding request; no speculation beyond the PC.
- Invariants:
  - Never two imem_req pulses without an intervening rvalid.
  - if_valid never asserts for a discarded response.

Test Plan:
- Reset then 1-cycle memory returning 0x00500093 at addr 0: req at cycle 0 → if_valid=1, if_pc=0, if_instr=0x00500093 at cycle 2; next req addr=4.
- Stall held 3 cycles while rvalid arrives for addr 8: data goes to HOLD, if_* unchanged, no req; on stall release if_pc=8 loads, next req addr=12.
- PcSel=1, BrPC=0x40 while in WAIT for addr 0x10, memory latency 3: state DRAIN, old rdata never appears on if_instr, if_valid=0, next req addr=0x40.
- PcSel=1 and imem_rvalid same cycle, BrPC=0x7F: response dropped, next req addr=0x7C, if_valid=0.
- PcSel=1 with stall=1 and if_valid=1: if_valid→0 next cycle, pc=target.
- PC=0x1FC, PC_W=9, sequential fetch: next req addr=0x000; reset asserted mid-WAIT → pc=RESET_PC, if_valid=0, late rvalid after reset ignored, fresh req to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit_if
// Brief   : Instruction-memory request/response bus between fetch and imem.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int PC_W = 9
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : IF stage with IF/ID register; one outstanding imem fetch, stall
//           hold buffer and redirect flush/drain.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            stall,
  input  wire logic            PcSel,
  input  wire logic [31:0]     BrPC,
  fetch_unit_if.master         imem,
  output logic [PC_W-1:0]      if_pc,
  output logic [31:0]          if_instr,
  output logic                 if_valid
);

  localparam logic [31:0]     C_NOP  = 32'h0000_0013;
  localparam logic [PC_W-1:0] C_STEP = PC_W'(4);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_hold;
  logic [PC_W-1:0] r_if_pc;
  logic [31:0]     r_if_instr;
  logic            r_if_valid;

  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_next;

  assign w_target  = {BrPC[PC_W-1:2], 2'b00};
  assign w_pc_next = r_pc + C_STEP;

  generate
    if (PC_W < 32) begin : g_unused_hi
      logic w_unused_brpc;
      assign w_unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};
    end else begin : g_unused_lo
      logic w_unused_brpc;
      assign w_unused_brpc = ^BrPC[1:0];
    end
  endgenerate

  // A redirect suppresses the request so the stale PC is never fetched.
  assign imem.imem_req  = (r_state == S_REQ) && !PcSel && !reset;
  assign imem.imem_addr = r_pc;

  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_hold     <= '0;
      r_if_pc    <= '0;
      r_if_instr <= C_NOP;
      r_if_valid <= 1'b0;
    end else begin
      if (!stall) begin
        r_if_valid <= 1'b0;
      end
      if (PcSel) begin
        r_pc       <= w_target;
        r_if_valid <= 1'b0;
        case (r_state)
          S_WAIT:  r_state <= imem.imem_rvalid ? S_REQ : S_DRAIN;
          // A response landing with the redirect ends the drain; waiting on
          // would hang with nothing outstanding.
          S_DRAIN: r_state <= imem.imem_rvalid ? S_REQ : S_DRAIN;
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem.imem_rvalid) begin
              if (!stall) begin
                r_if_pc    <= r_pc;
                r_if_instr <= imem.imem_rdata;
                r_if_valid <= 1'b1;
                r_pc       <= w_pc_next;
                r_state    <= S_REQ;
              end else begin
                r_hold  <= imem.imem_rdata;
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_if_pc    <= r_pc;
              r_if_instr <= r_hold;
              r_if_valid <= 1'b1;
              r_pc       <= w_pc_next;
              r_state    <= S_REQ;
            end
          end
          S_DRAIN: begin
            if (imem.imem_rvalid) begin
              r_state <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit with an imem responder model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          PC_W     = 9;
  localparam logic [8:0]  RESET_PC = 9'h000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        PcSel;
  logic [31:0] BrPC;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .PcSel    (PcSel),
    .BrPC     (BrPC),
    .imem     (bus.master),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_valid (if_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_min = 1;
  int lat_max = 1;

  // Memory responder state: one live request plus one orphaned by reset.
  bit         pend = 0;
  int         pend_cyc = 0;
  logic [8:0] pend_addr = '0;
  bit         stale = 0;
  int         stale_cyc = 0;
  bit         cur_rv = 0;

  logic [8:0] exp_pc = RESET_PC;
  int         n_deliv = 0;

  logic        o_req, o_valid, p_valid;
  logic [8:0]  o_addr, o_pc, p_pc;
  logic [31:0] o_instr, p_instr;
  bit          prev_stall = 0, prev_pcsel = 0, prev_reset = 1;

  function automatic logic [31:0] memword(input logic [8:0] a);
    if (a == 9'h000) return 32'h0050_0093;
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  task automatic cycle();
    bit rv_pend, rv_stale;
    rv_pend  = pend && (pend_cyc == cyc);
    rv_stale = stale && (stale_cyc == cyc);
    cur_rv   = rv_pend || rv_stale;
    bus.imem_rvalid = cur_rv;
    bus.imem_rdata  = rv_pend ? memword(pend_addr) : (32'hBAD0_0000 | 32'($urandom_range(0, 65535)));
    if (rv_pend)  pend  = 0;
    if (rv_stale) stale = 0;
    @(negedge clk);
    p_valid = o_valid; p_pc = o_pc; p_instr = o_instr;
    o_req = bus.imem_req; o_addr = bus.imem_addr;
    o_valid = if_valid; o_pc = if_pc; o_instr = if_instr;
    if (o_req) begin
      total++;
      if (pend) begin
        bad++;
        $display("FAIL req_outstanding cyc=%0d: req=1 addr=%h while a fetch is pending, want req=0", cyc, o_addr);
      end
    end
    if (prev_reset || prev_pcsel) begin
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush cyc=%0d: if_valid=%b want 0", cyc, o_valid);
      end
    end else if (prev_stall) begin
      total++;
      if ({o_valid, o_pc, o_instr} !== {p_valid, p_pc, p_instr}) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d: got v=%b pc=%h instr=%h want v=%b pc=%h instr=%h",
                 cyc, o_valid, o_pc, o_instr, p_valid, p_pc, p_instr);
      end
    end else if (o_valid === 1'b1) begin
      total++;
      n_deliv++;
      if (o_pc !== exp_pc || o_instr !== memword(exp_pc)) begin
        bad++;
        $display("FAIL delivery cyc=%0d: got pc=%h instr=%h want pc=%h instr=%h",
                 cyc, o_pc, o_instr, exp_pc, memword(exp_pc));
      end
      exp_pc = exp_pc + 9'd4;
    end
    if (o_req) begin
      pend      = 1;
      pend_addr = o_addr;
      pend_cyc  = cyc + $urandom_range(lat_min, lat_max);
    end
    @(posedge clk);
    prev_stall = stall; prev_pcsel = PcSel; prev_reset = reset;
    if (reset) begin
      exp_pc = RESET_PC;
      if (pend) begin
        stale = 1; stale_cyc = pend_cyc; pend = 0;
      end
    end else if (PcSel) begin
      exp_pc = {BrPC[8:2], 2'b00};
    end
    #1;
    cyc++;
  endtask

  task automatic wait_req(input logic [8:0] addr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (o_req === 1'b1 && o_addr === addr) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_req: no request for addr %h within 40 cycles, last addr=%h", addr, o_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; PcSel = 0; BrPC = '0;
    lat_min = 1; lat_max = 1;
    bus.imem_rvalid = 0; bus.imem_rdata = '0;
    @(posedge clk); #1;
    cycle();
    total++;
    if ({o_req, o_valid, o_pc, o_instr} !== {1'b0, 1'b0, 9'h000, NOP}) begin
      bad++;
      $display("FAIL reset_state: req=%b v=%b pc=%h instr=%h want 0 0 000 %h", o_req, o_valid, o_pc, o_instr, NOP);
    end
    reset = 0;
    cycle();
    total++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_first_req: req=%b addr=%h want 1 %h", o_req, o_addr, RESET_PC);
    end
  endtask

  task automatic test_first_fetch();
    cycle();
    cycle();
    total++;
    if ({o_valid, o_pc, o_instr, o_req, o_addr} !== {1'b1, 9'h000, 32'h0050_0093, 1'b1, 9'h004}) begin
      bad++;
      $display("FAIL first_fetch: v=%b pc=%h instr=%h req=%b addr=%h want 1 000 00500093 1 004",
               o_valid, o_pc, o_instr, o_req, o_addr);
    end
  endtask

  task automatic test_stall_hold();
    wait_req(9'h008);
    stall = 1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (o_req !== 1'b0 || o_pc !== 9'h004) begin
        bad++;
        $display("FAIL stall_hold_if: req=%b pc=%h want 0 004", o_req, o_pc);
      end
    end
    stall = 0;
    cycle();
    cycle();
    total++;
    if ({o_valid, o_pc, o_instr, o_req, o_addr} !== {1'b1, 9'h008, memword(9'h008), 1'b1, 9'h00C}) begin
      bad++;
      $display("FAIL stall_release: v=%b pc=%h instr=%h req=%b addr=%h want 1 008 %h 1 00C",
               o_valid, o_pc, o_instr, o_req, o_addr, memword(9'h008));
    end
  endtask

  task automatic test_redirect_drain();
    lat_min = 3; lat_max = 3;
    wait_req(9'h010);
    PcSel = 1; BrPC = 32'h0000_0040;
    cycle();
    PcSel = 0;
    cycle();
    cycle();
    total++;
    if (o_valid !== 1'b0 || o_req !== 1'b0) begin
      bad++;
      $display("FAIL drain_quiet: v=%b req=%b want 0 0", o_valid, o_req);
    end
    cycle();
    total++;
    if (o_req !== 1'b1 || o_addr !== 9'h040 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_target: req=%b addr=%h v=%b want 1 040 0", o_req, o_addr, o_valid);
    end
  endtask

  task automatic test_redirect_rvalid();
    lat_min = 1; lat_max = 1;
    wait_req(9'h044);
    PcSel = 1; BrPC = 32'h0000_007F;
    cycle();
    PcSel = 0;
    cycle();
    total++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 9'h07C) begin
      bad++;
      $display("FAIL redirect_rvalid: v=%b req=%b addr=%h want 0 1 07C", o_valid, o_req, o_addr);
    end
  endtask

  task automatic test_redirect_stall();
    bit got;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = cur_rv;
    end
    stall = 1;
    cycle();
    total++;
    if (o_valid !== 1'b1 || o_pc !== 9'h07C) begin
      bad++;
      $display("FAIL stall_loaded: v=%b pc=%h want 1 07C", o_valid, o_pc);
    end
    PcSel = 1; BrPC = 32'h0000_0100;
    cycle();
    PcSel = 0;
    cycle();
    total++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 9'h100) begin
      bad++;
      $display("FAIL redirect_stall: v=%b req=%b addr=%h want 0 1 100", o_valid, o_req, o_addr);
    end
    stall = 0;
  endtask

  task automatic test_wrap();
    bit seen;
    PcSel = 1; BrPC = 32'h0000_01F8;
    cycle();
    PcSel = 0;
    wait_req(9'h1FC);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = o_req;
    end
    total++;
    if (!seen || o_addr !== 9'h000) begin
      bad++;
      $display("FAIL pc_wrap: seen=%b addr=%h want 1 000", seen, o_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    lat_min = 3; lat_max = 3;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = o_req;
    end
    reset = 1;
    cycle();
    cycle();
    total++;
    if ({o_req, o_valid, o_pc, o_instr} !== {1'b0, 1'b0, 9'h000, NOP}) begin
      bad++;
      $display("FAIL mid_wait_reset: req=%b v=%b pc=%h instr=%h want 0 0 000 %h", o_req, o_valid, o_pc, o_instr, NOP);
    end
    reset = 0;
    lat_min = 1; lat_max = 1;
    cycle();
    total++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      bad++;
      $display("FAIL post_reset_req: req=%b addr=%h want 1 %h", o_req, o_addr, RESET_PC);
    end
    cycle();
    cycle();
    total++;
    if (o_valid !== 1'b1 || o_pc !== 9'h000 || o_instr !== 32'h0050_0093) begin
      bad++;
      $display("FAIL post_reset_fetch: v=%b pc=%h instr=%h want 1 000 00500093", o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_random();
    int start;
    start = n_deliv;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      PcSel = ($urandom_range(0, 19) == 0);
      BrPC  = $urandom;
      cycle();
    end
    stall = 0; PcSel = 0;
    for (int i = 0; i < 10; i++) cycle();
    total++;
    if (n_deliv - start < 100) begin
      bad++;
      $display("FAIL random_progress: %0d deliveries, want at least 100", n_deliv - start);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_rvalid();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
